game_ctrl: RTL and testbench

Frame-paced game controller for one round of duck flights. It drives the 2-bit `state` and the `shot` request into the duck sprite block, and consumes that block's `bird_shot` / `flew_away` pulses. It tracks shells, hits, ducks flown, round number and score for the HUD/scoreboard renderer.

---
 rtl/game_pkg.sv | 23 ++
 rtl/game_ctrl_if.sv | 29 ++
 rtl/game_ctrl_edge_sync.sv | 39 +++
 rtl/game_ctrl.sv | 171 +++++++++++++++++
 tb/tb_game_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared game types and defaults, used by game_ctrl and the duck sprite block.
package game_pkg;

  typedef enum logic [1:0] {
    TITLE  = 2'b00,
    INTRO  = 2'b01,
    FLYING = 2'b10,
    RESULT = 2'b11
  } game_state_t;

  localparam int unsigned DEF_SHELLS          = 3;
  localparam int unsigned DEF_DUCKS_PER_ROUND = 10;
  localparam int unsigned DEF_QUOTA           = 6;
  localparam int unsigned DEF_HIT_POINTS      = 500;

  // Score accumulate that pins at full scale instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/game_ctrl_if.sv
// Controller <-> duck block / HUD signal bundle. master = game_ctrl side.
interface game_ctrl_if;
  import game_pkg::*;

  logic        frame_clk;
  logic        start;
  logic        trigger;
  logic        bird_shot;
  logic        flew_away;
  game_state_t state;
  logic        shot;
  logic [1:0]  shells_left;
  logic [3:0]  ducks_hit;
  logic [3:0]  duck_count;
  logic [3:0]  round;
  logic [15:0] score;
  logic        last_hit;

  modport master (
    input  frame_clk, start, trigger, bird_shot, flew_away,
    output state, shot, shells_left, ducks_hit, duck_count, round, score, last_hit
  );

  modport slave (
    output frame_clk, start, trigger, bird_shot, flew_away,
    input  state, shot, shells_left, ducks_hit, duck_count, round, score, last_hit
  );

endinterface

// File: rtl/game_ctrl_edge_sync.sv
// edge_sync: DEPTH-stage synchronizer followed by a registered rising-edge
// detector. Output is a one-cycle pulse DEPTH+1 clocks after the input rises.
module edge_sync #(
  parameter int DEPTH = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic pulse
);

  logic [DEPTH-1:0] sync_q, sync_d;
  logic             dly_q, dly_d;
  logic             pulse_q, pulse_d;

  // Shift the input through the sync chain and flag 0->1 at its end.
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < DEPTH; i++) sync_d[i] = sync_q[i-1];
    dly_d   = sync_q[DEPTH-1];
    pulse_d = sync_q[DEPTH-1] & ~dly_q;
  end

  // Synchronous-reset register bank.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q  <= '0;
      dly_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      dly_q   <= dly_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// game_ctrl: frame-paced round controller for the duck game.
// Optional build macro GAME_CTRL_INFINITE_AMMO_EN: shells never run out and
// the out-of-ammo exit from FLYING is removed.
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned SHELLS          = DEF_SHELLS,
  parameter int unsigned DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
  parameter int unsigned QUOTA           = DEF_QUOTA,
  parameter int unsigned INTRO_FRAMES    = 60,
  parameter int unsigned RESULT_FRAMES   = 90,
  parameter int unsigned HIT_POINTS      = DEF_HIT_POINTS
) (
  input logic        Clk,
  input logic        Reset,
  game_ctrl_if.master gif
);

  localparam int unsigned FRM_MAX = (INTRO_FRAMES > RESULT_FRAMES) ? INTRO_FRAMES : RESULT_FRAMES;
  localparam int unsigned FW      = $clog2(FRM_MAX + 1);

  logic fe, fire;

  // Same frame-edge timing as the duck block sees.
  edge_sync #(.DEPTH(1)) u_fe   (.Clk(Clk), .Reset(Reset), .d(gif.frame_clk), .pulse(fe));
  edge_sync #(.DEPTH(2)) u_fire (.Clk(Clk), .Reset(Reset), .d(gif.trigger),   .pulse(fire));

  game_state_t   state_q, state_d;
  logic          shot_q, shot_d;
  logic [1:0]    shells_q, shells_d;
  logic [3:0]    hits_q, hits_d;
  logic [3:0]    count_q, count_d;
  logic [3:0]    round_q, round_d;
  logic [15:0]   score_q, score_d;
  logic          last_q, last_d;
  logic [FW-1:0] frm_q, frm_d;
  logic          leave;
  logic [3:0]    count_n;

  // Next-state and counter updates; everything holds unless a branch says otherwise.
  always_comb begin
    state_d  = state_q;
    shot_d   = shot_q;
    shells_d = shells_q;
    hits_d   = hits_q;
    count_d  = count_q;
    round_d  = round_q;
    score_d  = score_q;
    last_d   = last_q;
    frm_d    = frm_q;
    leave    = 1'b0;
    count_n  = (count_q < 4'(DUCKS_PER_ROUND)) ? count_q + 4'd1 : count_q;
    case (state_q)
      TITLE: begin
        if (gif.start) begin
          state_d = INTRO;
          round_d = 4'd1;
          score_d = '0;
          hits_d  = '0;
          count_d = '0;
          frm_d   = '0;
        end
      end
      INTRO: begin
        if (fe) begin
          if (frm_q == FW'(INTRO_FRAMES - 1)) begin
            state_d  = FLYING;
            shells_d = 2'(SHELLS);
            frm_d    = '0;
          end else begin
            frm_d = frm_q + 1'b1;
          end
        end
      end
      FLYING: begin
        if (fe) begin
          // A pending shot is delivered on this edge and then retires.
          shot_d = 1'b0;
          if (gif.flew_away) begin
            leave  = 1'b1;
            last_d = 1'b0;
          end else if (gif.bird_shot) begin
            leave   = 1'b1;
            last_d  = 1'b1;
            hits_d  = (hits_q < 4'(DUCKS_PER_ROUND)) ? hits_q + 4'd1 : hits_q;
            score_d = sat_add16(score_q, 16'(HIT_POINTS));
          end
`ifdef GAME_CTRL_INFINITE_AMMO_EN
`else
          else if (shot_q && shells_q == 2'd0) begin
            leave  = 1'b1;
            last_d = 1'b0;
          end
`endif
        end
        if (leave) begin
          state_d = RESULT;
          shot_d  = 1'b0;
          frm_d   = '0;
        end else if (fire && !shot_q && shells_q != 2'd0) begin
          // Fire on the edge cycle itself still arms a shot for the next edge.
          shot_d = 1'b1;
`ifdef GAME_CTRL_INFINITE_AMMO_EN
          shells_d = shells_q;
`else
          shells_d = shells_q - 2'd1;
`endif
        end
      end
      RESULT: begin
        if (fe) begin
          if (frm_q == FW'(RESULT_FRAMES - 1)) begin
            frm_d = '0;
            if (count_n == 4'(DUCKS_PER_ROUND)) begin
              if (hits_q >= 4'(QUOTA)) begin
                state_d = INTRO;
                round_d = (round_q == 4'hF) ? round_q : round_q + 4'd1;
                hits_d  = '0;
                count_d = '0;
              end else begin
                state_d = TITLE;
                count_d = count_n;
              end
            end else begin
              state_d = INTRO;
              count_d = count_n;
            end
          end else begin
            frm_d = frm_q + 1'b1;
          end
        end
      end
      default: state_d = TITLE;
    endcase
  end

  // State and counter registers, synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= TITLE;
      shot_q   <= 1'b0;
      shells_q <= '0;
      hits_q   <= '0;
      count_q  <= '0;
      round_q  <= '0;
      score_q  <= '0;
      last_q   <= 1'b0;
      frm_q    <= '0;
    end else begin
      state_q  <= state_d;
      shot_q   <= shot_d;
      shells_q <= shells_d;
      hits_q   <= hits_d;
      count_q  <= count_d;
      round_q  <= round_d;
      score_q  <= score_d;
      last_q   <= last_d;
      frm_q    <= frm_d;
    end
  end

  assign gif.state       = state_q;
  assign gif.shot        = shot_q;
  assign gif.shells_left = shells_q;
  assign gif.ducks_hit   = hits_q;
  assign gif.duck_count  = count_q;
  assign gif.round       = round_q;
  assign gif.score       = score_q;
  assign gif.last_hit    = last_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with default parameters.
module tb_game_ctrl;
  import game_pkg::*;

  logic Clk = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  game_ctrl_if gif();

  game_ctrl dut (.Clk(Clk), .Reset(Reset), .gif(gif.master));

  always #10 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // One frame_clk period (6 clocks). fe is high in the cycle after the 2nd
  // rising edge; shot_fe samples shot during that cycle.
  task automatic frame(input logic bs, input logic fa, output logic shot_fe);
    gif.bird_shot = bs;
    gif.flew_away = fa;
    gif.frame_clk = 1'b1;
    tick();
    tick();
    shot_fe = gif.shot;
    tick();
    gif.frame_clk = 1'b0;
    tick(); tick(); tick();
    gif.bird_shot = 1'b0;
    gif.flew_away = 1'b0;
  endtask

  task automatic run_frames(input int n);
    logic s;
    for (int i = 0; i < n; i++) frame(1'b0, 1'b0, s);
  endtask

  // Press and release; shot (if accepted) is visible when this returns.
  task automatic press();
    gif.trigger = 1'b1;
    tick(); tick(); tick(); tick();
    gif.trigger = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (gif.state !== TITLE) begin n_bad++; $display("FAIL rst_state got %0d want 0", gif.state); end
    n_cmp++; if (gif.shot !== 1'b0) begin n_bad++; $display("FAIL rst_shot got %0b want 0", gif.shot); end
    n_cmp++; if (gif.shells_left !== 2'd0) begin n_bad++; $display("FAIL rst_shells got %0d want 0", gif.shells_left); end
    n_cmp++; if (gif.ducks_hit !== 4'd0) begin n_bad++; $display("FAIL rst_hits got %0d want 0", gif.ducks_hit); end
    n_cmp++; if (gif.duck_count !== 4'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", gif.duck_count); end
    n_cmp++; if (gif.round !== 4'd0) begin n_bad++; $display("FAIL rst_round got %0d want 0", gif.round); end
    n_cmp++; if (gif.score !== 16'd0) begin n_bad++; $display("FAIL rst_score got %0d want 0", gif.score); end
    n_cmp++; if (gif.last_hit !== 1'b0) begin n_bad++; $display("FAIL rst_last got %0b want 0", gif.last_hit); end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_start();
    logic s;
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    n_cmp++; if (gif.state !== INTRO) begin n_bad++; $display("FAIL start_state got %0d want 1", gif.state); end
    n_cmp++; if (gif.round !== 4'd1) begin n_bad++; $display("FAIL start_round got %0d want 1", gif.round); end
    n_cmp++; if (gif.score !== 16'd0) begin n_bad++; $display("FAIL start_score got %0d want 0", gif.score); end
    run_frames(59);
    n_cmp++; if (gif.state !== INTRO) begin n_bad++; $display("FAIL intro59_state got %0d want 1", gif.state); end
    frame(1'b0, 1'b0, s);
    n_cmp++; if (gif.state !== FLYING) begin n_bad++; $display("FAIL intro60_state got %0d want 2", gif.state); end
    n_cmp++; if (gif.shells_left !== 2'd3) begin n_bad++; $display("FAIL intro60_shells got %0d want 3", gif.shells_left); end
  endtask

  task automatic test_hit();
    logic s;
    press();
    n_cmp++; if (gif.shot !== 1'b1) begin n_bad++; $display("FAIL hit_shot_set got %0b want 1", gif.shot); end
    n_cmp++; if (gif.shells_left !== 2'd2) begin n_bad++; $display("FAIL hit_shells_dec got %0d want 2", gif.shells_left); end
    frame(1'b1, 1'b0, s);
    n_cmp++; if (s !== 1'b1) begin n_bad++; $display("FAIL hit_shot_at_fe got %0b want 1", s); end
    n_cmp++; if (gif.shot !== 1'b0) begin n_bad++; $display("FAIL hit_shot_clr got %0b want 0", gif.shot); end
    n_cmp++; if (gif.state !== RESULT) begin n_bad++; $display("FAIL hit_state got %0d want 3", gif.state); end
    n_cmp++; if (gif.ducks_hit !== 4'd1) begin n_bad++; $display("FAIL hit_hits got %0d want 1", gif.ducks_hit); end
    n_cmp++; if (gif.score !== 16'd500) begin n_bad++; $display("FAIL hit_score got %0d want 500", gif.score); end
    n_cmp++; if (gif.last_hit !== 1'b1) begin n_bad++; $display("FAIL hit_last got %0b want 1", gif.last_hit); end
    n_cmp++; if (gif.shells_left !== 2'd2) begin n_bad++; $display("FAIL hit_shells got %0d want 2", gif.shells_left); end
    run_frames(89);
    n_cmp++; if (gif.state !== RESULT) begin n_bad++; $display("FAIL res89_state got %0d want 3", gif.state); end
    n_cmp++; if (gif.duck_count !== 4'd0) begin n_bad++; $display("FAIL res89_count got %0d want 0", gif.duck_count); end
    frame(1'b0, 1'b0, s);
    n_cmp++; if (gif.state !== INTRO) begin n_bad++; $display("FAIL res90_state got %0d want 1", gif.state); end
    n_cmp++; if (gif.duck_count !== 4'd1) begin n_bad++; $display("FAIL res90_count got %0d want 1", gif.duck_count); end
    run_frames(60);
    n_cmp++; if (gif.shells_left !== 2'd3) begin n_bad++; $display("FAIL duck2_shells got %0d want 3", gif.shells_left); end
  endtask

  task automatic test_no_ammo();
    logic s;
    press();
    frame(1'b0, 1'b0, s);
    n_cmp++; if (gif.state !== FLYING) begin n_bad++; $display("FAIL miss1_state got %0d want 2", gif.state); end
    n_cmp++; if (gif.shot !== 1'b0) begin n_bad++; $display("FAIL miss1_shot got %0b want 0", gif.shot); end
    press();
    n_cmp++; if (gif.shells_left !== 2'd1) begin n_bad++; $display("FAIL miss2_shells got %0d want 1", gif.shells_left); end
    frame(1'b0, 1'b0, s);
    press();
    n_cmp++; if (gif.shells_left !== 2'd0) begin n_bad++; $display("FAIL miss3_shells got %0d want 0", gif.shells_left); end
    press();
    n_cmp++; if (gif.shot !== 1'b1 || gif.shells_left !== 2'd0) begin n_bad++; $display("FAIL pend_press got shot=%0b shells=%0d want shot=1 shells=0", gif.shot, gif.shells_left); end
    frame(1'b0, 1'b0, s);
    n_cmp++; if (gif.state !== RESULT) begin n_bad++; $display("FAIL ammo_state got %0d want 3", gif.state); end
    n_cmp++; if (gif.last_hit !== 1'b0) begin n_bad++; $display("FAIL ammo_last got %0b want 0", gif.last_hit); end
    n_cmp++; if (gif.ducks_hit !== 4'd1) begin n_bad++; $display("FAIL ammo_hits got %0d want 1", gif.ducks_hit); end
    press();
    n_cmp++; if (gif.shot !== 1'b0) begin n_bad++; $display("FAIL press4_shot got %0b want 0", gif.shot); end
    run_frames(90);
    n_cmp++; if (gif.duck_count !== 4'd2) begin n_bad++; $display("FAIL duck2_count got %0d want 2", gif.duck_count); end
    run_frames(60);
  endtask

  task automatic test_priority();
    logic s;
    frame(1'b1, 1'b1, s);
    n_cmp++; if (gif.state !== RESULT) begin n_bad++; $display("FAIL prio_state got %0d want 3", gif.state); end
    n_cmp++; if (gif.last_hit !== 1'b0) begin n_bad++; $display("FAIL prio_last got %0b want 0", gif.last_hit); end
    n_cmp++; if (gif.ducks_hit !== 4'd1) begin n_bad++; $display("FAIL prio_hits got %0d want 1", gif.ducks_hit); end
    n_cmp++; if (gif.score !== 16'd500) begin n_bad++; $display("FAIL prio_score got %0d want 500", gif.score); end
    run_frames(90);
    n_cmp++; if (gif.duck_count !== 4'd3) begin n_bad++; $display("FAIL duck3_count got %0d want 3", gif.duck_count); end
    run_frames(60);
  endtask

  // Round 1 ducks 4..8 hit (6 hits total), 9..10 fly away -> round 2.
  // Round 2: 5 hits of 10 -> game over.
  task automatic test_round_end();
    logic s;
    for (int i = 4; i <= 10; i++) begin
      frame(i <= 8, i > 8, s);
      run_frames(90);
      if (i < 10) run_frames(60);
    end
    n_cmp++; if (gif.state !== INTRO) begin n_bad++; $display("FAIL r1end_state got %0d want 1", gif.state); end
    n_cmp++; if (gif.round !== 4'd2) begin n_bad++; $display("FAIL r1end_round got %0d want 2", gif.round); end
    n_cmp++; if (gif.ducks_hit !== 4'd0 || gif.duck_count !== 4'd0) begin n_bad++; $display("FAIL r1end_clr got hits=%0d count=%0d want 0/0", gif.ducks_hit, gif.duck_count); end
    n_cmp++; if (gif.score !== 16'd3000) begin n_bad++; $display("FAIL r1end_score got %0d want 3000", gif.score); end
    run_frames(60);
    for (int i = 1; i <= 10; i++) begin
      frame(i <= 5, i > 5, s);
      run_frames(90);
      if (i < 10) run_frames(60);
    end
    n_cmp++; if (gif.state !== TITLE) begin n_bad++; $display("FAIL r2end_state got %0d want 0", gif.state); end
    n_cmp++; if (gif.score !== 16'd5500) begin n_bad++; $display("FAIL r2end_score got %0d want 5500", gif.score); end
    n_cmp++; if (gif.round !== 4'd2) begin n_bad++; $display("FAIL r2end_round got %0d want 2", gif.round); end
    n_cmp++; if (gif.duck_count !== 4'd10) begin n_bad++; $display("FAIL r2end_count got %0d want 10", gif.duck_count); end
  endtask

  task automatic test_reset_mid();
    gif.start = 1'b1;
    tick(); tick(); tick();
    gif.start = 1'b0;
    n_cmp++; if (gif.state !== INTRO || gif.round !== 4'd1 || gif.score !== 16'd0) begin n_bad++; $display("FAIL restart got state=%0d round=%0d score=%0d want 1/1/0", gif.state, gif.round, gif.score); end
    run_frames(60);
    n_cmp++; if (gif.state !== FLYING) begin n_bad++; $display("FAIL restart_fly got %0d want 2", gif.state); end
    press();
    n_cmp++; if (gif.shot !== 1'b1) begin n_bad++; $display("FAIL mid_shot got %0b want 1", gif.shot); end
    Reset = 1'b1;
    tick();
    n_cmp++; if (gif.state !== TITLE || gif.shot !== 1'b0) begin n_bad++; $display("FAIL mid_rst got state=%0d shot=%0b want 0/0", gif.state, gif.shot); end
    n_cmp++; if (gif.shells_left !== 2'd0 || gif.ducks_hit !== 4'd0 || gif.duck_count !== 4'd0 || gif.round !== 4'd0 || gif.score !== 16'd0) begin
      n_bad++; $display("FAIL mid_rst_cnt got shells=%0d hits=%0d count=%0d round=%0d score=%0d want all 0", gif.shells_left, gif.ducks_hit, gif.duck_count, gif.round, gif.score);
    end
    Reset = 1'b0;
    tick();
  endtask

  initial begin
    Reset         = 1'b1;
    gif.frame_clk = 1'b0;
    gif.start     = 1'b0;
    gif.trigger   = 1'b0;
    gif.bird_shot = 1'b0;
    gif.flew_away = 1'b0;
    test_reset();
    test_start();
    test_hit();
    test_no_ammo();
    test_priority();
    test_round_end();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
